// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer and its buffer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/ifetch_buffer.sv
// PC-tagged instruction FIFO between the fetch sequencer and decode.
// A flush empties it and takes priority over any push or pop in the same cycle.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_pc,
  input  logic [WIDTH-1:0] i_push_instr,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head_pc,
  output logic [WIDTH-1:0] o_head_instr
);

  logic [WIDTH-1:0] r_pcMem    [DEPTH];
  logic [WIDTH-1:0] r_instrMem [DEPTH];
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pcMem[i]    <= '0;
        r_instrMem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_pcMem[r_wrPtr]    <= i_push_pc;
        r_instrMem[r_wrPtr] <= i_push_instr;
        r_wrPtr             <= r_wrPtr + AW'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pcMem[r_rdPtr];
  assign o_head_instr = r_instrMem[r_rdPtr];

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, issues one outstanding
// request at a time and buffers PC-tagged responses for decode.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fetch_en,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_excep_taken,
  input  logic [WIDTH-1:0] i_excep_target,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_instr_valid,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_instr_pc,
  input  logic             i_instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_stateNext;
  logic [WIDTH-1:0] r_fetchPc;
  logic [WIDTH-1:0] r_tagPc;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_targetAligned;
  logic             w_redirect;
  logic             w_req;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [CW-1:0]    w_count;

  // Exception beats branch; redirect targets are forced to word alignment.
  assign w_redirect      = i_excep_taken | i_branch_taken;
  assign w_target        = i_excep_taken ? i_excep_target : i_branch_target;
  assign w_targetAligned = {w_target[WIDTH-1:2], 2'b00};

  // Only request when a buffer slot is guaranteed free for the response.
  assign w_req   = !i_reset && (r_state == REQ) && i_fetch_en && (w_count < CW'(DEPTH));
  assign w_grant = w_req && i_imem_gnt;

  // A response arriving alongside a redirect is stale and never enters the buffer.
  assign w_push  = (r_state == WAIT) && i_imem_rvalid && !w_redirect;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && i_instr_ready && !w_redirect;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= REQ;
    else         r_state <= w_stateNext;
  end

  // Next-state logic; redirects route an in-flight request through DRAIN.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      REQ: begin
        if (w_grant) w_stateNext = w_redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (i_imem_rvalid)   w_stateNext = REQ;
        else if (w_redirect) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (i_imem_rvalid) w_stateNext = REQ;
      end
      default: w_stateNext = REQ;
    endcase
  end

  // Fetch PC: redirect overrides the sequential advance taken on each grant.
  always_ff @(posedge i_clk) begin
    if (i_reset)         r_fetchPc <= RESET_PC;
    else if (w_redirect) r_fetchPc <= w_targetAligned;
    else if (w_grant)    r_fetchPc <= r_fetchPc + WIDTH'(INSTR_BYTES);
  end

  // Tag register remembers which PC the outstanding request belongs to.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_tagPc <= '0;
    else if (w_grant) r_tagPc <= r_fetchPc;
  end

  ifetch_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buffer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_push),
    .i_push_pc    (r_tagPc),
    .i_push_instr (i_imem_rdata),
    .i_pop        (w_pop),
    .i_flush      (w_redirect),
    .o_count      (w_count),
    .o_head_pc    (o_instr_pc),
    .o_head_instr (o_instr)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_fetchPc;
  assign o_instr_valid = w_valid;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer with a small handshaked memory model
// and a scoreboard of expected instruction PCs drained by decode.
module tb_ifetch_sequencer;

  logic        clock;
  logic        reset;
  logic        fetchEn;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        excepTaken;
  logic [31:0] excepTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          gntDelay    = 0;
  int          rvalidDelay = 1;
  int          reqAge;
  logic        pend;
  int          pendLeft;
  logic [31:0] pendAddr;
  int          redirCycle;

  logic [31:0] expQ[$];
  logic [31:0] grantLog[$];
  int          grantCycle[$];
  int          popCycle[$];

  ifetch_sequencer #(.WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .i_clk           (clock),
    .i_reset         (reset),
    .i_fetch_en      (fetchEn),
    .i_branch_taken  (branchTaken),
    .i_branch_target (branchTarget),
    .i_excep_taken   (excepTaken),
    .i_excep_target  (excepTarget),
    .o_imem_req      (imemReq),
    .o_imem_addr     (imemAddr),
    .i_imem_gnt      (imemGnt),
    .i_imem_rvalid   (imemRvalid),
    .i_imem_rdata    (imemRdata),
    .o_instr_valid   (instrValid),
    .o_instr         (instr),
    .o_instr_pc      (instrPc),
    .i_instr_ready   (instrReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction word stored at an address; distinct per address so a wrong pairing shows up.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Memory grants after gntDelay cycles of a held request and answers rvalidDelay cycles later.
  assign imemGnt    = imemReq && (reqAge >= gntDelay);
  assign imemRvalid = pend && (pendLeft == 0);
  assign imemRdata  = imemRvalid ? memWord(pendAddr) : 32'h0;

  // Memory-side request/response bookkeeping; reset drops anything in flight.
  always @(posedge clock) begin
    if (reset) begin
      reqAge   <= 0;
      pend     <= 1'b0;
      pendLeft <= 0;
      pendAddr <= 32'h0;
    end else begin
      if (imemReq && !imemGnt) reqAge <= reqAge + 1;
      else                     reqAge <= 0;
      if (imemReq && imemGnt) begin
        pend     <= 1'b1;
        pendAddr <= imemAddr;
        pendLeft <= rvalidDelay - 1;
      end else if (pend && pendLeft == 0) begin
        pend <= 1'b0;
      end else if (pend) begin
        pendLeft <= pendLeft - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy,
                               input logic br, input logic [31:0] brT,
                               input logic ex, input logic [31:0] exT);
    fetchEn      = fe;
    instrReady   = rdy;
    branchTaken  = br;
    branchTarget = brT;
    excepTaken   = ex;
    excepTarget  = exT;
    #1;
  endtask

  // One clock: sample at the falling edge, log grants, score pops, then step past the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clock);
    cycle++;
    if (imemReq && imemGnt) begin
      grantLog.push_back(imemAddr);
      grantCycle.push_back(cycle);
    end
    if (instrValid && instrReady) begin
      popCycle.push_back(cycle);
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL sb_unexpected_pop: observed pc %h expected no instruction", instrPc);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sb_pc", instrPc, e);
        checkOutput("sb_instr", instr, memWord(e));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clearLogs();
    grantLog.delete();
    grantCycle.delete();
    popCycle.delete();
  endtask

  task automatic waitGrants(input string tag, input int n);
    for (int i = 0; i < 30 && grantLog.size() < n; i++) tick();
    checkOutput(tag, 32'(grantLog.size()), 32'(n));
  endtask

  task automatic drainQueue(input string tag);
    for (int i = 0; i < 30 && expQ.size() != 0; i++) tick();
    tick();
    tick();
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_req_during", {31'b0, imemReq}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_req", {31'b0, imemReq}, 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_valid", {31'b0, instrValid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc", instrPc, 32'h0);

    // Streaming with zero-wait memory and decode always ready.
    $display("[TB] streaming fetch");
    clearLogs();
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    waitGrants("t1_grants", 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("t1_drain");
    if (grantLog.size() == 3) begin
      checkOutput("t1_addr0", grantLog[0], 32'h0);
      checkOutput("t1_addr1", grantLog[1], 32'h4);
      checkOutput("t1_addr2", grantLog[2], 32'h8);
    end
    checkOutput("t1_pops", 32'(popCycle.size()), 32'd3);
    if (popCycle.size() == 3 && grantCycle.size() == 3) begin
      checkOutput("t1_latency", 32'(popCycle[0] - grantCycle[0]), 32'd2);
      checkOutput("t1_rate1", 32'(popCycle[1] - popCycle[0]), 32'd2);
      checkOutput("t1_rate2", 32'(popCycle[2] - popCycle[1]), 32'd2);
    end
    checkOutput("t1_req_off", {31'b0, imemReq}, 32'd0);

    // Decode stalled: buffer fills and requests stop, then drains in order.
    $display("[TB] stall and fill");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t2_fill_grants", 32'(grantLog.size()), 32'd2);
    checkOutput("t2_full_req", {31'b0, imemReq}, 32'd0);
    checkOutput("t2_full_valid", {31'b0, instrValid}, 32'd1);
    checkOutput("t2_full_head", instrPc, 32'hC);
    clearLogs();
    expQ.push_back(32'hC);
    expQ.push_back(32'h10);
    expQ.push_back(32'h14);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    waitGrants("t2_resume_grant", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("t2_drain");
    if (grantLog.size() != 0) checkOutput("t2_resume_addr", grantLog[0], 32'h14);

    // Slow grant: request and address must hold until accepted.
    $display("[TB] delayed grant");
    clearLogs();
    gntDelay = 3;
    expQ.push_back(32'h18);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_hold_req", {31'b0, imemReq}, 32'd1);
      checkOutput("t3_hold_addr", imemAddr, 32'h18);
      checkOutput("t3_no_gnt", {31'b0, imemGnt}, 32'd0);
      tick();
    end
    checkOutput("t3_gnt", {31'b0, imemGnt}, 32'd1);
    checkOutput("t3_gnt_addr", imemAddr, 32'h18);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("t3_drain");
    checkOutput("t3_single", 32'(grantLog.size()), 32'd1);
    gntDelay = 0;

    // Branch while waiting on a slow response: that response must be dropped.
    $display("[TB] branch during wait");
    clearLogs();
    rvalidDelay = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("t4_pre_grant", 32'(grantLog.size()), 32'd1);
    clearLogs();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h43, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t4_valid_after", {31'b0, instrValid}, 32'd0);
    checkOutput("t4_req_drain", {31'b0, imemReq}, 32'd0);
    checkOutput("t4_addr_aligned", imemAddr, 32'h40);
    rvalidDelay = 1;
    expQ.push_back(32'h40);
    waitGrants("t4_grant", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("t4_drain");
    if (grantLog.size() != 0) checkOutput("t4_addr", grantLog[0], 32'h40);

    // Exception and branch together: exception target wins.
    $display("[TB] exception priority");
    clearLogs();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
    tick();
    redirCycle = cycle;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_addr", imemAddr, 32'h100);
    checkOutput("t5_req", {31'b0, imemReq}, 32'd1);
    checkOutput("t5_valid_after", {31'b0, instrValid}, 32'd0);
    expQ.push_back(32'h100);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("t5_drain");
    if (grantLog.size() != 0) checkOutput("t5_grant_addr", grantLog[0], 32'h100);
    if (popCycle.size() != 0) checkOutput("t5_latency", 32'(popCycle[0] - redirCycle), 32'd3);

    // Reset while a request is outstanding and one entry is buffered.
    $display("[TB] reset mid-transaction");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rvalidDelay = 4;
    tick();
    checkOutput("t6_pre_valid", {31'b0, instrValid}, 32'd1);
    checkOutput("t6_pre_pc", instrPc, 32'h104);
    checkOutput("t6_pre_wait", {31'b0, imemReq}, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_valid", {31'b0, instrValid}, 32'd0);
    checkOutput("t6_addr", imemAddr, 32'h0);
    checkOutput("t6_req", {31'b0, imemReq}, 32'd0);
    checkOutput("t6_pc", instrPc, 32'h0);
    checkOutput("t6_instr", instr, 32'h0);
    rvalidDelay = 1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t6_no_stale", {31'b0, instrValid}, 32'd0);

    checkOutput("sb_leftover", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
